// File: rtl/pcie_tx_pkg.sv
// Shared types and constants for the PCIe transmit path.
// FSM encodings, requester IDs and the transfer watchdog default.
package pcie_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    typedef logic owner_t;

    localparam owner_t OWN_CPL = 1'b0;
    localparam owner_t OWN_MWR = 1'b1;

    localparam logic [9:0] WDOG_MAX_DEF = 10'd511;

    // One beat of requester traffic as seen by the arbiter.
    typedef struct packed {
        logic        st;
        logic        eop;
        logic [15:0] data;
    } tlp_beat_t;

endpackage

// File: rtl/tlp_tx_arbiter_if.sv
// Requester and PCIe-core transmit signals of the TLP arbiter.
// master: the arbiter itself; slave: requesters plus core.
interface tlp_tx_arbiter_if;

    logic        cpl_req;
    logic        cpl_st;
    logic        cpl_end;
    logic [15:0] cpl_data;
    logic        cpl_gnt;

    logic        mwr_req;
    logic        mwr_st;
    logic        mwr_end;
    logic [15:0] mwr_data;
    logic [12:0] mwr_pd;
    logic        mwr_gnt;

    logic        tx_req;
    logic        tx_rdy;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;
    logic [8:0]  tx_ca_ph;
    logic [12:0] tx_ca_pd;
    logic        tx_ca_p_recheck;

    modport master (
        input  cpl_req, cpl_st, cpl_end, cpl_data,
        output cpl_gnt,
        input  mwr_req, mwr_st, mwr_end, mwr_data, mwr_pd,
        output mwr_gnt,
        output tx_req,
        input  tx_rdy,
        output tx_st, tx_end, tx_data,
        input  tx_ca_ph, tx_ca_pd, tx_ca_p_recheck
    );

    modport slave (
        output cpl_req, cpl_st, cpl_end, cpl_data,
        input  cpl_gnt,
        output mwr_req, mwr_st, mwr_end, mwr_data, mwr_pd,
        input  mwr_gnt,
        input  tx_req,
        output tx_rdy,
        input  tx_st, tx_end, tx_data,
        output tx_ca_ph, tx_ca_pd, tx_ca_p_recheck
    );

endinterface

// File: rtl/tlp_credit_chk.sv
// Posted-credit eligibility: a header credit is available and the
// data credits cover the payload; MSB means infinite when INF_BIT is set.
module tlp_credit_chk #(
    parameter bit INF_BIT = 1'b1
) (
    input  logic [8:0]  ph,
    input  logic [12:0] pd,
    input  logic [12:0] need,
    output logic        ok
);

    logic ph_ok;
    logic pd_ok;

    assign ph_ok = (ph != 9'd0) || (INF_BIT && ph[8]);
    assign pd_ok = (pd >= need) || (INF_BIT && pd[12]);
    assign ok    = ph_ok && pd_ok;

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Round-robin transmit arbiter between completion and posted-write
// requesters, credit gated, with a watchdog on stuck transfers.
module tlp_tx_arbiter
    import pcie_tx_pkg::*;
#(
    parameter logic [9:0] WDOG_MAX = WDOG_MAX_DEF,
    parameter bit         INF_BIT  = 1'b1
) (
    input  logic             clk_125,
    input  logic             core_rst_n,
    tlp_tx_arbiter_if.master bus,
    output logic [15:0]      tlp_cnt_cpl,
    output logic [15:0]      tlp_cnt_mwr,
    output logic             wdog_err
);

    arb_state_t  state_q, state_d;
    owner_t      owner_q, owner_d;
    owner_t      last_q, last_d;
    logic [9:0]  wd_q, wd_d;
    logic [9:0]  wd_inc;

    logic        tx_req_q, tx_req_d;
    logic        cgnt_q, cgnt_d;
    logic        mgnt_q, mgnt_d;
    logic        st_q, st_d;
    logic        eop_q, eop_d;
    logic [15:0] data_q, data_d;
    logic [15:0] cnt_cpl_q, cnt_cpl_d;
    logic [15:0] cnt_mwr_q, cnt_mwr_d;
    logic        err_q, err_d;

    logic        crd_ok;
    logic        cpl_elig;
    logic        mwr_elig;
    tlp_beat_t   cpl_beat;
    tlp_beat_t   mwr_beat;
    tlp_beat_t   own_beat;

    tlp_credit_chk #(
        .INF_BIT (INF_BIT)
    ) u_crd (
        .ph   (bus.tx_ca_ph),
        .pd   (bus.tx_ca_pd),
        .need (bus.mwr_pd),
        .ok   (crd_ok)
    );

    assign cpl_elig = bus.cpl_req;
    assign mwr_elig = bus.mwr_req && crd_ok;

    assign cpl_beat = {bus.cpl_st, bus.cpl_end, bus.cpl_data};
    assign mwr_beat = {bus.mwr_st, bus.mwr_end, bus.mwr_data};
    assign own_beat = (owner_q == OWN_MWR) ? mwr_beat : cpl_beat;

    assign wd_inc = wd_q + 10'd1;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wd_d      = wd_q;
        tx_req_d  = tx_req_q;
        cgnt_d    = 1'b0;
        mgnt_d    = 1'b0;
        st_d      = 1'b0;
        eop_d     = 1'b0;
        data_d    = data_q;
        cnt_cpl_d = cnt_cpl_q;
        cnt_mwr_d = cnt_mwr_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (cpl_elig || mwr_elig) begin
                    // On a tie the requester that did not go last wins.
                    if (cpl_elig && mwr_elig) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = mwr_elig ? OWN_MWR : OWN_CPL;
                    end
                    state_d  = REQ;
                    tx_req_d = 1'b1;
                end
            end
            REQ: begin
                if (bus.tx_rdy) begin
                    state_d  = XFER;
                    tx_req_d = 1'b0;
                    cgnt_d   = (owner_q == OWN_CPL);
                    mgnt_d   = (owner_q == OWN_MWR);
                    last_d   = owner_q;
                    wd_d     = 10'd0;
                end else if ((owner_q == OWN_MWR) &&
                             bus.tx_ca_p_recheck && !crd_ok) begin
                    state_d  = IDLE;
                    tx_req_d = 1'b0;
                end
            end
            XFER: begin
                st_d   = own_beat.st;
                eop_d  = own_beat.eop;
                data_d = own_beat.data;
                wd_d   = wd_inc;
                if (own_beat.eop) begin
                    state_d = IDLE;
                    if (owner_q == OWN_MWR) begin
                        cnt_mwr_d = cnt_mwr_q + 16'd1;
                    end else begin
                        cnt_cpl_d = cnt_cpl_q + 16'd1;
                    end
                end else if (wd_inc == WDOG_MAX) begin
                    // Stuck transfer: close the TLP on the core side.
                    eop_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_125 or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_CPL;
            last_q    <= OWN_MWR;
            wd_q      <= 10'd0;
            tx_req_q  <= 1'b0;
            cgnt_q    <= 1'b0;
            mgnt_q    <= 1'b0;
            st_q      <= 1'b0;
            eop_q     <= 1'b0;
            data_q    <= 16'd0;
            cnt_cpl_q <= 16'd0;
            cnt_mwr_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            tx_req_q  <= tx_req_d;
            cgnt_q    <= cgnt_d;
            mgnt_q    <= mgnt_d;
            st_q      <= st_d;
            eop_q     <= eop_d;
            data_q    <= data_d;
            cnt_cpl_q <= cnt_cpl_d;
            cnt_mwr_q <= cnt_mwr_d;
            err_q     <= err_d;
        end
    end

    assign bus.tx_req  = tx_req_q;
    assign bus.cpl_gnt = cgnt_q;
    assign bus.mwr_gnt = mgnt_q;
    assign bus.tx_st   = st_q;
    assign bus.tx_end  = eop_q;
    assign bus.tx_data = data_q;

    assign tlp_cnt_cpl = cnt_cpl_q;
    assign tlp_cnt_mwr = cnt_mwr_q;
    assign wdog_err    = err_q;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Bench for tlp_tx_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_tlp_tx_arbiter;

    localparam int WDOG   = 511;
    localparam int M_IDLE = 0;
    localparam int M_ASK  = 1;
    localparam int M_SEND = 2;

    logic        clk_125    = 1'b0;
    logic        core_rst_n = 1'b1;
    logic [15:0] tlp_cnt_cpl;
    logic [15:0] tlp_cnt_mwr;
    logic        wdog_err;

    int n_vec = 0;
    int n_bad = 0;

    tlp_tx_arbiter_if bus ();

    tlp_tx_arbiter #(
        .WDOG_MAX (10'd511),
        .INF_BIT  (1'b1)
    ) dut (
        .clk_125     (clk_125),
        .core_rst_n  (core_rst_n),
        .bus         (bus),
        .tlp_cnt_cpl (tlp_cnt_cpl),
        .tlp_cnt_mwr (tlp_cnt_mwr),
        .wdog_err    (wdog_err)
    );

    always #4 clk_125 = ~clk_125;

    // reference model
    int          m_mode;
    bit          m_own;
    bit          m_last;
    int          m_xc;
    bit          e_req, e_cg, e_mg, e_st, e_end, e_err;
    logic [15:0] e_data, e_cc, e_cm;

    // requester agents
    int c_left, m_left, c_len, m_len, raise_pct;
    bit c_first, m_first, m_noend, rand_on;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit mwr_fits();
        bit hdr, dat;
        hdr = (int'(bus.tx_ca_ph) > 0) || (int'(bus.tx_ca_ph) >= 256);
        dat = (int'(bus.tx_ca_pd) >= int'(bus.mwr_pd)) ||
              (int'(bus.tx_ca_pd) >= 4096);
        return hdr && dat;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_own  = 1'b0;
        m_last = 1'b1;
        m_xc   = 0;
        e_req = 0; e_cg = 0; e_mg = 0; e_st = 0; e_end = 0; e_err = 0;
        e_data = 16'd0; e_cc = 16'd0; e_cm = 16'd0;
    endtask

    task automatic model_edge();
        bit          ce, me, o_st, o_end;
        logic [15:0] o_data;
        ce     = bus.cpl_req;
        me     = bus.mwr_req && mwr_fits();
        o_st   = m_own ? bus.mwr_st : bus.cpl_st;
        o_end  = m_own ? bus.mwr_end : bus.cpl_end;
        o_data = m_own ? bus.mwr_data : bus.cpl_data;
        e_cg = 0; e_mg = 0; e_st = 0; e_end = 0;
        case (m_mode)
            M_IDLE: begin
                if (ce || me) begin
                    m_own  = (ce && me) ? !m_last : me;
                    m_mode = M_ASK;
                    e_req  = 1;
                end
            end
            M_ASK: begin
                if (bus.tx_rdy) begin
                    e_req  = 0;
                    e_mg   = m_own;
                    e_cg   = !m_own;
                    m_last = m_own;
                    m_xc   = 0;
                    m_mode = M_SEND;
                end else if (m_own && bus.tx_ca_p_recheck && !mwr_fits()) begin
                    e_req  = 0;
                    m_mode = M_IDLE;
                end
            end
            default: begin
                e_st   = o_st;
                e_end  = o_end;
                e_data = o_data;
                m_xc++;
                if (o_end) begin
                    if (m_own) e_cm = e_cm + 16'd1;
                    else       e_cc = e_cc + 16'd1;
                    m_mode = M_IDLE;
                end else if (m_xc == WDOG) begin
                    e_end  = 1;
                    e_err  = 1;
                    m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("tx_req",  32'(bus.tx_req),  32'(e_req));
        chk("cpl_gnt", 32'(bus.cpl_gnt), 32'(e_cg));
        chk("mwr_gnt", 32'(bus.mwr_gnt), 32'(e_mg));
        chk("tx_st",   32'(bus.tx_st),   32'(e_st));
        chk("tx_end",  32'(bus.tx_end),  32'(e_end));
        chk("tx_data", 32'(bus.tx_data), 32'(e_data));
        chk("cnt_cpl", 32'(tlp_cnt_cpl), 32'(e_cc));
        chk("cnt_mwr", 32'(tlp_cnt_mwr), 32'(e_cm));
        chk("wdog_err", 32'(wdog_err),   32'(e_err));
    endtask

    task automatic agents();
        if (e_cg) begin
            bus.cpl_req = 1'b0;
            c_left  = (c_len > 0) ? c_len : $urandom_range(1, 6);
            c_first = 1;
        end
        if (c_left > 0) begin
            bus.cpl_st   = c_first;
            bus.cpl_end  = (c_left == 1);
            bus.cpl_data = 16'($urandom);
            c_left--;
            c_first = 0;
        end else begin
            bus.cpl_st   = 1'($urandom);
            bus.cpl_end  = 1'($urandom);
            bus.cpl_data = 16'($urandom);
            if (!bus.cpl_req && $urandom_range(0, 99) < raise_pct)
                bus.cpl_req = 1'b1;
        end
        if (e_mg) begin
            bus.mwr_req = 1'b0;
            m_left  = (m_len > 0) ? m_len : $urandom_range(1, 6);
            m_first = 1;
        end
        if (m_left > 0) begin
            bus.mwr_st   = m_first;
            bus.mwr_end  = !m_noend && (m_left == 1);
            bus.mwr_data = 16'($urandom);
            m_left--;
            m_first = 0;
        end else begin
            bus.mwr_st   = 1'($urandom);
            bus.mwr_end  = 1'($urandom);
            bus.mwr_data = 16'($urandom);
            if (!bus.mwr_req && $urandom_range(0, 99) < raise_pct) begin
                bus.mwr_req = 1'b1;
                if (rand_on) bus.mwr_pd = 13'($urandom_range(0, 10));
            end
        end
        if (rand_on) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.tx_ca_ph = 9'h000;
                    1:       bus.tx_ca_ph = 9'h100;
                    default: bus.tx_ca_ph = 9'($urandom_range(1, 20));
                endcase
            end
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 4) == 0) bus.tx_ca_pd = 13'h1000;
                else bus.tx_ca_pd = 13'($urandom_range(0, 12));
            end
            bus.tx_ca_p_recheck = ($urandom_range(0, 4) == 0);
            bus.tx_rdy          = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic cyc();
        @(posedge clk_125);
        model_edge();
        #1;
        check_all();
        agents();
    endtask

    task automatic do_reset();
        core_rst_n = 1'b0;
        bus.cpl_req = 0; bus.cpl_st = 0; bus.cpl_end = 0; bus.cpl_data = 0;
        bus.mwr_req = 0; bus.mwr_st = 0; bus.mwr_end = 0; bus.mwr_data = 0;
        bus.mwr_pd = 0; bus.tx_rdy = 0; bus.tx_ca_p_recheck = 0;
        bus.tx_ca_ph = 0; bus.tx_ca_pd = 0;
        c_left = 0; m_left = 0; c_len = 0; m_len = 0;
        c_first = 0; m_first = 0; m_noend = 0;
        raise_pct = 0; rand_on = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk_125);
        #1;
        check_all();
        @(negedge clk_125);
        core_rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nreq, ng, seen, hi, t_g, t_e;
        int got [4];

        #2;
        do_reset();

        // single completion, late tx_rdy
        c_len = 3;
        bus.cpl_req = 1'b1;
        nreq = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            nreq += int'(bus.tx_req);
        end
        bus.tx_rdy = 1'b1;
        cyc();
        chk("cpl_gnt_pulse", 32'(bus.cpl_gnt), 32'd1);
        bus.tx_rdy = 1'b0;
        repeat (6) begin
            cyc();
            nreq += int'(bus.tx_req);
        end
        chk("req_cycles", 32'(nreq), 32'd3);
        chk("cnt_cpl_one", 32'(tlp_cnt_cpl), 32'd1);

        // tie: alternation starting with cpl
        do_reset();
        bus.tx_ca_ph = 9'h010;
        bus.tx_ca_pd = 13'h0040;
        bus.mwr_pd   = 13'd2;
        c_len = 2; m_len = 2; raise_pct = 100;
        bus.cpl_req = 1'b1;
        bus.mwr_req = 1'b1;
        bus.tx_rdy  = 1'b1;
        ng = 0;
        got = '{default: 0};
        for (int i = 0; i < 200 && ng < 4; i++) begin
            cyc();
            if (bus.cpl_gnt || bus.mwr_gnt) begin
                got[ng] = int'(bus.mwr_gnt);
                ng++;
            end
        end
        chk("tie_grants", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) chk("tie_order", 32'(got[k]), 32'(k % 2));
        raise_pct = 0;
        repeat (20) cyc();

        // credit block, then release
        do_reset();
        bus.tx_ca_ph = 9'd1;
        bus.tx_ca_pd = 13'd4;
        bus.mwr_pd   = 13'd8;
        bus.mwr_req  = 1'b1;
        hi = 0;
        repeat (5) begin
            cyc();
            hi |= int'(bus.tx_req);
        end
        chk("cred_block", 32'(hi), 32'd0);
        bus.tx_ca_pd = 13'd8;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (bus.tx_req) seen = 1;
        end
        chk("cred_ok_req", 32'(seen), 32'd1);

        // recheck drop while waiting for the core
        cyc();
        bus.tx_ca_pd = 13'd0;
        bus.tx_ca_p_recheck = 1'b1;
        cyc();
        chk("rechk_req", 32'(bus.tx_req), 32'd0);
        chk("rechk_gnt", 32'(bus.mwr_gnt), 32'd0);
        bus.tx_ca_p_recheck = 1'b0;
        cyc();
        chk("rechk_idle", 32'(bus.tx_req), 32'd0);
        bus.tx_ca_pd = 13'd8;
        bus.tx_rdy   = 1'b1;
        m_len = 1;
        repeat (8) cyc();
        chk("cnt_mwr_one", 32'(tlp_cnt_mwr), 32'd1);

        // watchdog on a TLP that never ends
        do_reset();
        bus.tx_ca_ph = 9'd1;
        bus.tx_ca_pd = 13'd8;
        bus.mwr_pd   = 13'd1;
        m_len = 600; m_noend = 1;
        bus.mwr_req = 1'b1;
        bus.tx_rdy  = 1'b1;
        t_g = -1000; t_e = -1;
        for (int i = 0; i < 800 && t_e < 0; i++) begin
            cyc();
            if (bus.mwr_gnt) t_g = i;
            if (bus.tx_end)  t_e = i;
        end
        chk("wdog_len", 32'(t_e - t_g), 32'd511);
        chk("wdog_err_set", 32'(wdog_err), 32'd1);
        chk("wdog_cnt", 32'(tlp_cnt_mwr), 32'd0);
        m_left = 0; m_noend = 0;
        repeat (5) cyc();
        chk("wdog_sticky", 32'(wdog_err), 32'd1);

        // reset in the middle of a transfer
        c_len = 20;
        bus.cpl_req = 1'b1;
        repeat (4) cyc();
        chk("in_xfer", 32'(m_mode), 32'(M_SEND));
        do_reset();
        chk("rst_err_clr", 32'(wdog_err), 32'd0);

        // completion counter wrap from a preloaded value
        force dut.cnt_cpl_q = 16'hFFFF;
        #1;
        release dut.cnt_cpl_q;
        e_cc = 16'hFFFF;
        c_len = 1;
        bus.cpl_req = 1'b1;
        bus.tx_rdy  = 1'b1;
        repeat (6) cyc();
        chk("cnt_wrap", 32'(tlp_cnt_cpl), 32'd0);

        // random traffic
        do_reset();
        bus.tx_ca_ph = 9'd4;
        bus.tx_ca_pd = 13'd6;
        rand_on = 1;
        raise_pct = 30;
        repeat (3000) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
